// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : dmem_pkg
//  Purpose : Shared types, constants and helpers for the line-granular data
//            memory responder (FSM state encoding, line geometry, index
//            extraction from a byte address).
//  Rev     : 1.0  initial release
// ============================================================================
package dmem_pkg;

  // One cache line is 32 bytes; the low 5 address bits select a byte
  // inside the line and are ignored by the memory.
  localparam int unsigned LINE_BYTES = 32;
  localparam int unsigned OFFSET_W   = 5;

  // Latency counter width; covers LATENCY up to 255.
  localparam int unsigned CNT_W      = 8;

  // Widest byte address the index helper accepts.
  localparam int unsigned ADDR_MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_e;

  // Line index of a byte address: drop the in-line offset, keep idx_w bits.
  // Bits above the index are masked off, so addresses alias modulo
  // (2**idx_w) lines.
  function automatic logic [ADDR_MAX_W-1:0] idx_of(
    input logic [ADDR_MAX_W-1:0] addr,
    input int unsigned           idx_w
  );
    logic [ADDR_MAX_W-1:0] mask;
    mask = (ADDR_MAX_W'(1) << idx_w) - ADDR_MAX_W'(1);
    return (addr >> OFFSET_W) & mask;
  endfunction

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/dmem_line_array.sv
`default_nettype none
// ============================================================================
//  Module  : dmem_line_array
//  Purpose : DEPTH x DATA_W line storage. Synchronous write, combinational
//            read. Contents are deliberately not reset.
//  Ports   : clk_i    - clock
//            we_i     - write enable (full-line write on rising edge)
//            waddr_i  - line index written
//            wdata_i  - line data written
//            raddr_i  - line index read
//            rdata_o  - line data at raddr_i (combinational)
//  Rev     : 1.0  initial release
// ============================================================================
module dmem_line_array #(
  parameter int unsigned DATA_W = 256,
  parameter int unsigned DEPTH  = 512,
  parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : dmem_line_array
`default_nettype wire

// File: rtl/data_memory_responder.sv
`default_nettype none
// ============================================================================
//  Module  : data_memory_responder
//  Purpose : Memory-side responder for the data cache. Accepts one full-line
//            read or write at a time, waits a fixed LATENCY, then pulses ack
//            for one cycle. Reads return the line on data_o during the ack
//            cycle and hold it until the next read ack.
//  Ports   : clk_i    - clock, rising edge
//            rst_i    - asynchronous active-low reset
//            addr_i   - byte address of the requested line
//            data_i   - write line data
//            enable_i - request valid (sampled only in IDLE)
//            write_i  - 1 = write line, 0 = read line
//            ack_o    - one-cycle completion pulse
//            data_o   - read line data (valid in a read ack, held after)
//            busy_o   - request in flight (WAIT or ACK)
//  Rev     : 1.0  initial release
// ============================================================================
module data_memory_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W  = 256,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DEPTH   = 512,
  parameter int unsigned LATENCY = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              enable_i,
  input  logic              write_i,
  output logic              ack_o,
  output logic [DATA_W-1:0] data_o,
  output logic              busy_o
);

  localparam int unsigned      IDX_W    = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'(LATENCY - 1);

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [IDX_W-1:0]   req_idx_q, req_idx_d;
  logic               req_write_q, req_write_d;
  logic [DATA_W-1:0]  req_data_q, req_data_d;
  logic [DATA_W-1:0]  data_q, data_d;

  // --------------------------------------------------------------------------
  // Line index of the incoming address
  // --------------------------------------------------------------------------
  logic [ADDR_MAX_W-1:0] w_addr_ext;
  logic [ADDR_MAX_W-1:0] w_in_idx_full;
  logic [IDX_W-1:0]      w_in_idx;
  logic                  w_unused_idx_bits;

  assign w_addr_ext        = ADDR_MAX_W'(addr_i);
  assign w_in_idx_full     = idx_of(w_addr_ext, IDX_W);
  assign w_in_idx          = w_in_idx_full[IDX_W-1:0];
  // Upper bits are always zero after masking; folded here so they are
  // visibly consumed.
  assign w_unused_idx_bits = ^w_in_idx_full[ADDR_MAX_W-1:IDX_W];

  // --------------------------------------------------------------------------
  // Effective request for the edge that enters ACK. With LATENCY=1 the
  // request is accepted and completed on the same edge, so the live inputs
  // must be used instead of the (not yet loaded) latches.
  // --------------------------------------------------------------------------
  logic [IDX_W-1:0]  w_eff_idx;
  logic              w_eff_write;
  logic [DATA_W-1:0] w_eff_data;
  logic              w_enter_ack;
  logic              w_array_we;
  logic [DATA_W-1:0] w_array_rdata;

  assign w_eff_idx   = (state_q == IDLE) ? w_in_idx : req_idx_q;
  assign w_eff_write = (state_q == IDLE) ? write_i  : req_write_q;
  assign w_eff_data  = (state_q == IDLE) ? data_i   : req_data_q;
  assign w_enter_ack = (state_d == ACK) && (state_q != ACK);

  // The array has no reset, so gate the write with reset to guarantee an
  // aborted request never lands in storage.
  assign w_array_we  = w_enter_ack && w_eff_write && rst_i;

  dmem_line_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_line_array (
    .clk_i   (clk_i),
    .we_i    (w_array_we),
    .waddr_i (w_eff_idx),
    .wdata_i (w_eff_data),
    .raddr_i (w_eff_idx),
    .rdata_o (w_array_rdata)
  );

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    req_idx_d   = req_idx_q;
    req_write_d = req_write_q;
    req_data_d  = req_data_q;

    unique case (state_q)
      IDLE: begin
        if (enable_i) begin
          req_idx_d   = w_in_idx;
          req_write_d = write_i;
          req_data_d  = data_i;
          count_d     = LOAD_CNT;
          state_d     = (LATENCY == 1) ? ACK : WAIT;
        end
      end

      WAIT: begin
        // Inputs are ignored here; only the countdown advances.
        count_d = count_q - CNT_W'(1);
        if (count_q <= CNT_W'(1)) begin
          count_d = '0;
          state_d = ACK;
        end
      end

      ACK: begin
        // enable_i is deliberately not sampled in ACK.
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  // Read data is captured on the edge entering ACK; write acks leave it.
  always_comb begin
    data_d = data_q;
    if (w_enter_ack && !w_eff_write) begin
      data_d = w_array_rdata;
    end
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      count_q     <= '0;
      req_idx_q   <= '0;
      req_write_q <= 1'b0;
      req_data_q  <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      req_idx_q   <= req_idx_d;
      req_write_q <= req_write_d;
      req_data_q  <= req_data_d;
      data_q      <= data_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign ack_o  = (state_q == ACK);
  assign busy_o = (state_q != IDLE);
  assign data_o = data_q;

endmodule : data_memory_responder
`default_nettype wire

// File: tb/tb_data_memory_responder.sv
`default_nettype none
// ============================================================================
//  Module  : tb_data_memory_responder
//  Purpose : Self-checking bench. Two responders (LATENCY 10 and 1) share a
//            clock. Stimulus pushes expected acks into a per-DUT queue; a
//            negedge monitor compares ack/busy/data against the queue and a
//            line-level memory model.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_data_memory_responder;

  localparam int DATA_W = 256;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 512;

  typedef struct {
    int                 due;
    bit                 is_write;
    bit                 chk;
    int                 idx;
    logic [DATA_W-1:0]  data;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n [2];
  logic              en    [2];
  logic              wr    [2];
  logic [ADDR_W-1:0] addr  [2];
  logic [DATA_W-1:0] wdata [2];
  logic              ack   [2];
  logic              busy  [2];
  logic [DATA_W-1:0] rdata [2];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  exp_t sb0[$];
  exp_t sb1[$];

  logic [DATA_W-1:0] model_mem [2][DEPTH];
  bit                written   [2][DEPTH];
  logic [DATA_W-1:0] last_data [2];
  bit                last_known[2];
  int                bfrom     [2];
  int                buntil    [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_memory_responder #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .LATENCY(10)
  ) u_dut0 (
    .clk_i(clk), .rst_i(rst_n[0]), .addr_i(addr[0]), .data_i(wdata[0]),
    .enable_i(en[0]), .write_i(wr[0]), .ack_o(ack[0]), .data_o(rdata[0]),
    .busy_o(busy[0])
  );

  data_memory_responder #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .LATENCY(1)
  ) u_dut1 (
    .clk_i(clk), .rst_i(rst_n[1]), .addr_i(addr[1]), .data_i(wdata[1]),
    .enable_i(en[1]), .write_i(wr[1]), .ack_o(ack[1]), .data_o(rdata[1]),
    .busy_o(busy[1])
  );

  function automatic int lat(input int k);
    return (k == 0) ? 10 : 1;
  endfunction

  function automatic logic [DATA_W-1:0] rand_line();
    logic [DATA_W-1:0] v;
    for (int i = 0; i < DATA_W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic chk(input string nm, input int k,
                     input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cyc=%0d: got %h expected %h", nm, k, cyc, act, exp);
    end
  endtask

  // ---------------- scoreboard queue helpers ----------------
  function automatic bit sb_peek(input int k, output exp_t e);
    if (k == 0) begin
      if (sb0.size() == 0) return 1'b0;
      e = sb0[0];
    end else begin
      if (sb1.size() == 0) return 1'b0;
      e = sb1[0];
    end
    return 1'b1;
  endfunction

  function automatic void sb_pop(input int k);
    if (k == 0) void'(sb0.pop_front());
    else        void'(sb1.pop_front());
  endfunction

  function automatic void sb_push(input int k, input exp_t e);
    if (k == 0) sb0.push_back(e);
    else        sb1.push_back(e);
  endfunction

  function automatic int sb_size(input int k);
    return (k == 0) ? sb0.size() : sb1.size();
  endfunction

  // Model state after a reset: nothing in flight, data_o cleared.
  function automatic void model_reset(input int k);
    if (k == 0) sb0.delete();
    else        sb1.delete();
    bfrom[k]      = 0;
    buntil[k]     = -1;
    last_data[k]  = '0;
    last_known[k] = 1'b1;
  endfunction

  // ---------------- monitor ----------------
  task automatic mon(input int k);
    exp_t e;
    bit   have;
    bit   exp_ack;
    bit   exp_busy;
    have     = sb_peek(k, e);
    exp_ack  = have && (e.due == cyc);
    exp_busy = (cyc >= bfrom[k]) && (cyc <= buntil[k]);
    chk("ack", k, DATA_W'(ack[k]), DATA_W'(exp_ack));
    chk("busy", k, DATA_W'(busy[k]), DATA_W'(exp_busy));
    if (have && e.due < cyc) begin
      // Stale entry: its ack slot has passed (already reported above).
      sb_pop(k);
    end else if (exp_ack) begin
      sb_pop(k);
      if (e.is_write) begin
        model_mem[k][e.idx] = e.data;
        written[k][e.idx]   = 1'b1;
        if (last_known[k]) chk("data_hold_wr", k, rdata[k], last_data[k]);
      end else begin
        if (e.chk) begin
          chk("rd_data", k, rdata[k], e.data);
          last_data[k]  = e.data;
          last_known[k] = 1'b1;
        end else begin
          last_known[k] = 1'b0;
        end
      end
    end else if (last_known[k]) begin
      chk("data_hold", k, rdata[k], last_data[k]);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) mon(k);
  end

  // ---------------- stimulus ----------------
  // Called at a negedge when the model says the DUT will be IDLE on the next
  // rising edge. Returns just after the accepting edge.
  task automatic issue(input int k, input bit w, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d);
    exp_t e;
    int   acc;
    en[k] = 1'b1; wr[k] = w; addr[k] = a; wdata[k] = d;
    @(posedge clk); #1;
    acc        = cyc;
    e.due      = acc + lat(k) - 1;
    e.is_write = w;
    e.idx      = int'(a / 32) % DEPTH;
    if (w) begin
      e.data = d;
      e.chk  = 1'b1;
    end else begin
      e.data = model_mem[k][e.idx];
      e.chk  = written[k][e.idx];
    end
    sb_push(k, e);
    bfrom[k]  = acc;
    buntil[k] = acc + lat(k) - 1;
  endtask

  // Full request: issue, scramble inputs while in flight, return at the
  // negedge before the first edge where a new request can be accepted.
  task automatic req(input int k, input bit w, input logic [ADDR_W-1:0] a,
                     input logic [DATA_W-1:0] d, input bit keep_en);
    issue(k, w, a, d);
    for (int i = 0; i < lat(k); i++) begin
      @(negedge clk);
      en[k] = keep_en; wr[k] = 1'($urandom); addr[k] = $urandom;
      wdata[k] = rand_line();
    end
    @(negedge clk);
  endtask

  task automatic idle(input int k, input int n);
    en[k] = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic random_reqs(input int k, input int n);
    int                line;
    logic [ADDR_W-1:0] a;
    bit                keep;
    for (int i = 0; i < n; i++) begin
      line = $urandom_range(0, 7);
      // Random offset and random upper bits: both must be ignored.
      a    = ($urandom & 32'hFFFF_C01F) | ADDR_W'(line * 32);
      keep = (i < n - 1) ? 1'($urandom) : 1'b0;
      req(k, 1'($urandom), a, rand_line(), keep);
      if (!keep) idle(k, $urandom_range(0, 3));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [DATA_W-1:0] pat_a;
    logic [DATA_W-1:0] pat_b;
    for (int k = 0; k < 2; k++) begin
      rst_n[k] = 1'b0; en[k] = 1'b0; wr[k] = 1'b0; addr[k] = '0; wdata[k] = '0;
      model_reset(k);
      for (int i = 0; i < DEPTH; i++) begin
        model_mem[k][i] = '0;
        written[k][i]   = 1'b0;
      end
    end
    repeat (3) @(negedge clk);
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    @(negedge clk);

    // Write then read a line, DEADBEEF replicated.
    req(0, 1'b1, 32'h0000_0040, {8{32'hDEADBEEF}}, 1'b0);
    idle(0, 2);
    req(0, 1'b0, 32'h0000_0040, '0, 1'b0);
    idle(0, 3);

    // Aliasing: 0x405F maps to the same line as 0x40.
    req(0, 1'b1, 32'h0000_0040, DATA_W'(32'h1234), 1'b0);
    req(0, 1'b0, 32'h0000_405F, '0, 1'b0);
    idle(0, 2);

    // Back-to-back with enable held high, alternating write/read to 0x80.
    for (int i = 0; i < 6; i++) begin
      req(0, (i % 2) == 0, 32'h0000_0080, rand_line(), i < 5);
    end
    idle(0, 2);

    // Reset mid-write aborts the write.
    pat_a = rand_line();
    pat_b = ~pat_a;
    req(0, 1'b1, 32'h0000_00C0, pat_a, 1'b0);
    idle(0, 1);
    issue(0, 1'b1, 32'h0000_00C0, pat_b);
    en[0] = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    rst_n[0] = 1'b0;
    model_reset(0);
    #1;
    chk("rst_busy_immediate", 0, DATA_W'(busy[0]), '0);
    chk("rst_ack_immediate", 0, DATA_W'(ack[0]), '0);
    repeat (2) @(negedge clk);
    rst_n[0] = 1'b1;
    @(negedge clk);
    req(0, 1'b0, 32'h0000_00C0, '0, 1'b0);
    idle(0, 2);

    random_reqs(0, 40);

    // LATENCY=1 instance.
    req(1, 1'b1, 32'h0000_0040, {8{32'hCAFEF00D}}, 1'b0);
    req(1, 1'b0, 32'h0000_405F, '0, 1'b0);
    idle(1, 2);
    random_reqs(1, 40);

    idle(0, 15);
    idle(1, 1);
    chk("sb_drain", 0, DATA_W'(sb_size(0)), '0);
    chk("sb_drain", 1, DATA_W'(sb_size(1)), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_data_memory_responder
`default_nettype wire

// File: doc/data_memory_responder.md
Name: data_memory_responder

Overview:
- Line-granular backing data memory; the memory-side responder to the data cache controller's request interface (enable/write/addr/data in, ack/data out).
- Accepts one cache-line read or write at a time.
- Models a fixed access latency, then returns a single-cycle ack.
- Sits below the dcache in the CPU's MEM stage hierarchy; it is the block the cache's mem_* ports connect to.

Parameters:
- DATA_W, 256: cache line width in bits (32 bytes).
- ADDR_W, 32: byte address width.
- DEPTH, 512: number of lines stored; must be a power of 2.
- LATENCY, 10: cycles from request acceptance to ack; legal range 1..255.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset, asynchronous, active-low.
- addr_i  input  ADDR_W  byte address of the requested line.
- data_i  input  DATA_W  write line data.
- enable_i  input  1  request valid.
- write_i  input  1  1 = write line, 0 = read line.
- ack_o  output  1  one-cycle completion pulse.
- data_o  output  DATA_W  read line data, valid while ack_o is high for a read.
- busy_o  output  1  high while a request is in flight (WAIT or ACK).

Behaviour:
- Reset (rst_i low, asynchronous): state=IDLE, count=0, ack_o=0, data_o=0, busy_o=0, latched request cleared.
  - Storage array contents are not reset.
  - Reset asserted mid-request aborts it: no array write occurs and no ack is issued.
- Line index: idx = addr_i[5 +: log2(DEPTH)]. Bits [4:0] are ignored. Upper bits beyond the index are ignored, so addresses alias modulo DEPTH*32 bytes.
- State machine: IDLE -> WAIT -> ACK -> IDLE.
- IDLE:
  - If enable_i=1 at a clock edge, latch idx, write_i and data_i, load count=LATENCY-1, go to WAIT (busy_o=1).
  - If LATENCY=1, go straight to ACK.
- WAIT: count decrements each cycle; when count reaches 1, go to ACK on the next edge. Inputs are ignored while in WAIT; changes to addr_i, data_i or write_i have no effect.
- Timing: a request accepted at edge t puts ack_o high during the cycle after edge t+LATENCY-1, i.e. ack is first visible LATENCY cycles after acceptance.
- ACK (exactly one cycle):
  - ack_o=1.
  - Read: data_o = array[latched idx], registered on entry to ACK.
  - Write: array[latched idx] <= latched data at the edge entering ACK, so a read issued next sees the new data.
  - Next state is always IDLE; enable_i is not sampled in ACK.
- After ACK, ack_o returns to 0.
  - data_o holds the last read line until the next read ack; a write ack leaves data_o unchanged.
- Back-to-back requests: enable_i held high through ACK is accepted again on the first IDLE cycle. Minimum spacing is LATENCY+1 cycles per request.
- No partial-line writes; a write always replaces the full DATA_W line.

Decomposition:
- Package dmem_pkg:
  - state enum {IDLE, WAIT, ACK}, 2 bits.
  - LINE_BYTES=32, OFFSET_W=5.
  - Function idx_of(addr) returning the index slice.
- Sub-module dmem_line_array: DEPTH x DATA_W storage with synchronous write and combinational read.
- The responder holds the FSM, latency counter and request latches.

Test Plan:
- Reset, then write addr=0x00000040 with data=0xDEADBEEF replicated, LATENCY=10 -> ack_o high for exactly 1 cycle, 10 cycles after acceptance; busy_o high for those 10 cycles.
- Read addr=0x00000040 after that write -> ack 10 cycles later; data_o=0xDEADBEEF replicated in the ack cycle and held afterwards.
- Read addr=0x0000405F with DEPTH=512 (aliases index 2 of the 16 KB space) after writing 0x1234 at addr=0x00000040 -> data_o=0x1234, since bits [4:0] and bits above the index are ignored.
- enable_i held high continuously, alternating write/read to addr=0x80 -> acks spaced exactly LATENCY+1 cycles apart; addr_i/data_i changed during WAIT have no effect.
- rst_i pulsed low 5 cycles into a write to addr=0xC0 -> ack_o stays 0, busy_o=0 immediately; a subsequent read of 0xC0 returns the pre-write contents.
- LATENCY=1: read request -> ack_o in the very next cycle; correct data returned.
